// File: rtl/matadd_stream.sv
// Streaming element-wise matrix add/subtract with wrap or signed-saturating lanes.
// One output register stage; the input is back-pressured straight from the output handshake.
module matadd_stream #(
  parameter int DW    = 32,
  parameter int ROWS  = 2,
  parameter int COLS  = 3,
  parameter int LANES = 1,
  parameter int RW    = 16,
  localparam int RBW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CBW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  input  logic [1:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [RBW-1:0]        out_row,
  output logic [CBW-1:0]        out_col,
  output logic                  out_last,
  output logic                  out_sat,
  output logic [RW-1:0]         mat_count
);

  generate
    if (COLS % LANES != 0) begin : g_bad_lanes
      $error("matadd_stream: COLS must be a multiple of LANES");
    end
  endgenerate

  logic [RBW-1:0]      row;
  logic [CBW-1:0]      col;
  logic [1:0]          mode;
  logic                accept;
  logic                first_beat;
  logic                last_beat;
  logic                col_end;
  logic [1:0]          eff_op;
  logic [LANES*DW-1:0] res;
  logic                sat_any;
  logic [DW-1:0]       a_lane;
  logic [DW-1:0]       b_lane;
  logic [DW:0]         sum;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (row == '0) && (col == '0);
  assign col_end    = (col == CBW'(COLS - LANES));
  assign last_beat  = (row == RBW'(ROWS - 1)) && col_end;
  // The index-0 beat uses op directly so the first beat already sees the new mode.
  assign eff_op     = first_beat ? op : mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      mode <= 2'b00;
    end else if (accept) begin
      if (first_beat) mode <= op;
      if (last_beat) begin
        row <= '0;
        col <= '0;
      end else if (col_end) begin
        row <= row + 1'b1;
        col <= '0;
      end else begin
        col <= col + CBW'(LANES);
      end
    end
  end

  // Sign-extend to DW+1 bits; overflow shows as disagreement of the top two bits.
  always_comb begin
    res     = '0;
    sat_any = 1'b0;
    a_lane  = '0;
    b_lane  = '0;
    sum     = '0;
    for (int k = 0; k < LANES; k++) begin
      a_lane = in_a[k*DW +: DW];
      b_lane = in_b[k*DW +: DW];
      if (eff_op[0]) sum = {a_lane[DW-1], a_lane} - {b_lane[DW-1], b_lane};
      else           sum = {a_lane[DW-1], a_lane} + {b_lane[DW-1], b_lane};
      if (eff_op[1] && (sum[DW] != sum[DW-1])) begin
        sat_any = 1'b1;
        res[k*DW +: DW] = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        res[k*DW +: DW] = sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      mat_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_row   <= row;
        out_col   <= col;
        out_last  <= last_beat;
        out_sat   <= sat_any;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_last) mat_count <= mat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_matadd_stream.sv
// Directed bench for matadd_stream: a default 2x3 scalar instance and a DW=8, 3-lane, 1x3 instance.
module tb_matadd_stream;

  logic        clk;
  logic        rst;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_last0, out_sat0;
  logic [31:0] in_a0, in_b0, out_data0;
  logic [1:0]  op0;
  logic [0:0]  out_row0;
  logic [1:0]  out_col0;
  logic [15:0] mat_count0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, out_sat1;
  logic [23:0] in_a1, in_b1, out_data1;
  logic [1:0]  op1;
  logic [0:0]  out_row1;
  logic [1:0]  out_col1;
  logic [15:0] mat_count1;

  int n_vectors;
  int n_miscompares;

  matadd_stream u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0), .op(op0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_row(out_row0), .out_col(out_col0), .out_last(out_last0), .out_sat(out_sat0),
    .mat_count(mat_count0)
  );

  matadd_stream #(.DW(8), .ROWS(1), .COLS(3), .LANES(3), .RW(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .op(op1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_row(out_row1), .out_col(out_col1), .out_last(out_last1), .out_sat(out_sat1),
    .mat_count(mat_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    in_a0 = a;
    in_b0 = b;
    op0 = o;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyLaneStimulus(input logic [23:0] a, input logic [23:0] b, input logic [1:0] o);
    in_a1 = a;
    in_b1 = b;
    op1 = o;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_add [6] = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 32'd66};
  logic [31:0] exp_sub [6] = '{32'hFFFF_FFF7, 32'hFFFF_FFEE, 32'hFFFF_FFE5,
                               32'hFFFF_FFDC, 32'hFFFF_FFD3, 32'hFFFF_FFCA};
  logic [0:0]  exp_row [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0]  exp_col [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  logic [23:0] lane_a   [6] = '{24'h7F7F7F, 24'h7F7F7F, 24'h808080, 24'h808080, 24'h80107F, 24'h051020};
  logic [23:0] lane_b   [6] = '{24'h010101, 24'h010101, 24'h010101, 24'h010101, 24'hFF2001, 24'h032001};
  logic [1:0]  lane_op  [6] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
  logic [23:0] lane_exp [6] = '{24'h7F7F7F, 24'h808080, 24'h808080, 24'h7F7F7F, 24'h80307F, 24'h02F01F};
  logic        lane_sat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic checkBeat(input string tag, input int i, input logic [31:0] exp_d);
    checkOutput({tag, " valid"}, 64'(out_valid0), 64'd1);
    checkOutput({tag, " data"},  64'(out_data0),  64'(exp_d));
    checkOutput({tag, " row"},   64'(out_row0),   64'(exp_row[i]));
    checkOutput({tag, " col"},   64'(out_col0),   64'(exp_col[i]));
    checkOutput({tag, " last"},  64'(out_last0),  64'(i == 5));
    checkOutput({tag, " sat"},   64'(out_sat0),   64'd0);
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    rst = 1'b1;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; op0 = 2'b00; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; op1 = 2'b00; out_ready1 = 1'b1;

    #12;
    checkOutput("reset out_valid", 64'(out_valid0), 64'd0);
    checkOutput("reset out_data",  64'(out_data0),  64'd0);
    checkOutput("reset out_last",  64'(out_last0),  64'd0);
    checkOutput("reset mat_count", 64'(mat_count0), 64'd0);
    checkOutput("reset in_ready",  64'(in_ready0),  64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic add matrix");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b00);
      checkBeat("add", i, exp_add[i]);
    end
    idleCycle();
    checkOutput("add drained", 64'(out_valid0), 64'd0);
    checkOutput("add mat_count", 64'(mat_count0), 64'd1);

    $display("[TB] op change mid-matrix");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), (i >= 3) ? 2'b01 : 2'b00);
      checkBeat("opchg", i, exp_add[i]);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b01);
      checkBeat("sub", i, exp_sub[i]);
    end
    idleCycle();
    checkOutput("sub mat_count", 64'(mat_count0), 64'd3);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b00);
      checkBeat("bp pre", i, exp_add[i]);
    end
    out_ready0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(32'd4, 32'd40, 2'b00);
      checkBeat("bp hold", 2, exp_add[2]);
      checkOutput("bp in_ready", 64'(in_ready0), 64'd0);
    end
    out_ready0 = 1'b1;
    for (int i = 3; i < 6; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b00);
      checkBeat("bp post", i, exp_add[i]);
    end
    idleCycle();
    checkOutput("bp mat_count", 64'(mat_count0), 64'd4);

    $display("[TB] reset mid-matrix");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b00);
      checkBeat("prerst", i, exp_add[i]);
    end
    in_valid0 = 1'b0;
    #2 rst = 1'b1;
    #2;
    checkOutput("midrst out_valid", 64'(out_valid0), 64'd0);
    checkOutput("midrst mat_count", 64'(mat_count0), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'(i + 1), 32'(10 * (i + 1)), 2'b00);
      checkBeat("postrst", i, exp_add[i]);
    end
    idleCycle();
    checkOutput("postrst mat_count", 64'(mat_count0), 64'd1);

    $display("[TB] 8-bit three-lane saturation");
    for (int i = 0; i < 6; i++) begin
      applyLaneStimulus(lane_a[i], lane_b[i], lane_op[i]);
      checkOutput("lane valid", 64'(out_valid1), 64'd1);
      checkOutput("lane data",  64'(out_data1),  64'(lane_exp[i]));
      checkOutput("lane sat",   64'(out_sat1),   64'(lane_sat[i]));
      checkOutput("lane last",  64'(out_last1),  64'd1);
      checkOutput("lane col",   64'(out_col1),   64'd0);
    end
    idleCycle();
    checkOutput("lane mat_count", 64'(mat_count1), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/matadd_stream.md
# matadd_stream

Streaming, parametrised element-wise matrix adder/subtractor for the accelerator datapath. It accepts a ROWS x COLS operand pair as a sequence of beats, LANES elements per beat, in row-major order, over a valid/ready handshake, and returns the result matrix as a stream in the same order. Per matrix it can add or subtract, with either wrap-around or signed-saturating arithmetic. The block sits between the operand buffers and the next pipeline stage, and replaces fully-parallel per-element adder arrays when matrices are large.

## Interface
- DW, 32, element width in bits, two's complement.
- ROWS, 2, matrix rows, >= 1.
- COLS, 3, matrix columns, >= 1.
- LANES, 1, elements per beat. COLS % LANES == 0 is required; an elaboration-time error fires otherwise.
- RW, 16, width of the completed-matrix counter.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operand beat is present.
- in_ready  out  1  the block can accept a beat.
- in_a  in  LANES*DW  operand A elements; lane k is at [k*DW +: DW].
- in_b  in  LANES*DW  operand B elements, same packing as in_a.
- op  in  2  mode: 00 add/wrap, 01 sub/wrap (A-B), 10 add/sat, 11 sub/sat.
- out_valid  out  1  a result beat is present.
- out_ready  in  1  the downstream stage accepts the result beat.
- out_data  out  LANES*DW  result elements, same packing as the inputs.
- out_row  out  max(1,$clog2(ROWS))  row index of the beat.
- out_col  out  max(1,$clog2(COLS))  column index of lane 0.
- out_last  out  1  last beat of a matrix.
- out_sat  out  1  at least one lane of the beat was clamped.
- mat_count  out  RW  number of matrices fully delivered; wraps modulo 2^RW.

## Operation
- BEATS = ROWS*COLS/LANES. An internal beat counter runs 0..BEATS-1, tracked as a row counter and a column counter. The column counter advances by LANES per beat.
- Input handshake: a beat is accepted when in_valid && in_ready. A beat is never consumed when in_ready is 0.
- Mode latch: op is sampled on the accepted beat whose index is 0, and held for the remaining beats of that matrix. Changes to op in mid-matrix are ignored until the next matrix.
- Per-lane arithmetic is computed on DW+1 bits:
  - wrap modes: the result is the low DW bits; out_sat is 0.
  - sat modes: signed overflow clamps the lane to 2^(DW-1)-1 when positive or -2^(DW-1) when negative. out_sat is the OR across lanes of "lane clamped".
- Index and flag generation:
  - out_row and out_col reflect the counter values at acceptance.
  - out_last = 1 when the beat index == BEATS-1.
  - After the beat with index BEATS-1 is accepted, both counters return to 0 (wrap-around).
- mat_count increments by 1 on the output handshake of a beat with out_last = 1.
- State: the beat counter, the latched mode, one output register stage (data + index + flags + valid), and mat_count. There is no further buffering.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid, out_data, out_row, out_col, out_last, out_sat, and mat_count are all 0.
  - The beat counter is 0 and the latched mode is 00.
- in_ready = !out_valid || out_ready, combinational. It is 1 during and immediately after reset.
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure: while out_valid && !out_ready, all output fields hold stable and in_ready = 0.
- Simultaneous events:
  - A beat can be accepted in the same cycle the held beat drains; the output register reloads without a bubble.
  - If an input accept and an out_last drain occur in the same cycle, both take effect.
- Reset mid-matrix: the partial matrix is discarded, the counters return to 0, and the output beat is dropped. The next accepted beat is treated as index 0 of a new matrix.

## Test plan
- Defaults (DW=32, ROWS=2, COLS=3, LANES=1), op=00, A = 1..6, B = 10..60, out_ready held at 1:
  - Required response: 6 beats 11,22,33,44,55,66.
  - Rows/cols are (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); out_last is 1 only on the 6th beat; mat_count = 1.
- DW=8, LANES=3, op=10, A lane = 0x7F, B lane = 0x01:
  - Required response: every lane = 0x7F and out_sat = 1.
  - With op=00 and the same operands, every lane = 0x80 and out_sat = 0.
- DW=8, op=11, A = 0x80, B = 0x01 -> result 0x80 with out_sat = 1. With op=01 -> result 0x7F with out_sat = 0.
- Change op from 00 to 01 at beat 3 of a matrix -> all 6 beats are added. The next matrix, started with op=01, is subtracted.
- Drive out_ready = 0 for 4 cycles mid-stream:
  - Required response: the output holds its value, in_ready = 0, and no beat is lost or duplicated.
  - Results resume in order after out_ready returns to 1.
- Assert rst after beat 2, then send a full matrix -> the first post-reset output has out_row=0 and out_col=0, and mat_count = 1 after the matrix completes.
